// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch stage feeding IF/ID; one outstanding imem
//            request, one-word hold buffer, redirect kills in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazDetect_IF_ID,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] pcPlusFour_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_fpc;
  logic [31:0] r_hold;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_inst;
  logic        r_inst_valid;

  logic        w_consume;
  logic [31:0] w_target;
  logic [31:0] w_fpc_plus4;

  assign w_consume   = r_inst_valid & hazDetect_IF_ID & ~redirect;
  assign w_target    = redirect_pc & ~32'h0000_0003;
  assign w_fpc_plus4 = r_fpc + 32'd4;

  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_fpc;
  assign pc_o         = r_pc;
  assign pcPlusFour_o = r_pc4;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_inst_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fpc        <= RESET_PC;
      r_hold       <= '0;
      r_pc         <= '0;
      r_pc4        <= '0;
      r_inst       <= BUBBLE_INST;
      r_inst_valid <= 1'b0;
    end else begin
      // Default on consume; a load in the same cycle overrides it below.
      if (w_consume) begin
        r_inst_valid <= 1'b0;
        r_inst       <= BUBBLE_INST;
      end
      if (redirect) begin
        r_inst_valid <= 1'b0;
        r_inst       <= BUBBLE_INST;
        r_hold       <= '0;
        r_fpc        <= w_target;
        case (r_state)
          S_REQ:   r_state <= imem_gnt ? S_DROP : S_REQ;
          S_WAIT:  r_state <= imem_rvalid ? S_REQ : S_DROP;
          S_DROP:  r_state <= imem_rvalid ? S_REQ : S_DROP;
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            if (imem_gnt) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (!r_inst_valid || w_consume) begin
                r_pc         <= r_fpc;
                r_pc4        <= w_fpc_plus4;
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
                r_fpc        <= w_fpc_plus4;
                r_state      <= S_REQ;
              end else begin
                r_hold  <= imem_rdata;
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_consume) begin
              r_pc         <= r_fpc;
              r_pc4        <= w_fpc_plus4;
              r_inst       <= r_hold;
              r_inst_valid <= 1'b1;
              r_fpc        <= w_fpc_plus4;
              r_hold       <= '0;
              r_state      <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem_rvalid) r_state <= S_REQ;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Self-checking bench for if_fetch_stage (directed vectors plus
//            randomized traffic against a program-order reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] B = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        haz = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_o;
  logic [31:0] pcPlusFour_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0), .BUBBLE_INST(B)) dut (
    .clk(clk), .rst(rst), .hazDetect_IF_ID(haz), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_o(pc_o), .pcPlusFour_o(pcPlusFour_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o)
  );

  typedef struct {
    logic        rs, h, rd;
    logic [31:0] rpc;
    logic        g, rv;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_ppf, e_inst;
  } vec_t;

  // Instruction memory content: odd-multiplier hash, distinct per address.
  function automatic logic [31:0] D(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t V(input logic rs, h, rd, input logic [31:0] rpc,
                             input logic g, rv, input logic [31:0] rdat,
                             input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, epp, ei);
    vec_t v;
    v.rs = rs; v.h = h; v.rd = rd; v.rpc = rpc; v.g = g; v.rv = rv; v.rdat = rdat;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ppf = epp; v.e_inst = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; haz = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare current outputs, then drive this row's inputs across one edge.
  task automatic run_vec(input vec_t v, input string tag);
    chk({tag, ".req"},   {31'd0, imem_req},     {31'd0, v.e_req});
    chk({tag, ".addr"},  imem_addr,             v.e_addr);
    chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, v.e_valid});
    chk({tag, ".pc"},    pc_o,                  v.e_pc);
    chk({tag, ".ppf"},   pcPlusFour_o,          v.e_ppf);
    chk({tag, ".inst"},  inst_o,                v.e_inst);
    rst = v.rs; haz = v.h; redirect = v.rd; redirect_pc = v.rpc;
    imem_gnt = v.g; imem_rvalid = v.rv; imem_rdata = v.rdat;
    @(posedge clk); @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    int unsigned mem_out, mem_cnt, idle, consumed;
    logic [31:0] mem_addr, exp_pc, prev_pc, prev_inst;
    logic        prev_stall;

    // Streaming fetch, then a 6-cycle stall that buffers one word.
    tbl.push_back(V(0,1,0,0,1,0,0,       0,32'h0, 0,32'h0,32'h0,B));
    tbl.push_back(V(0,1,0,0,1,0,0,       1,32'h0, 0,32'h0,32'h0,B));
    tbl.push_back(V(0,1,0,0,1,1,D(0),    0,32'h0, 0,32'h0,32'h0,B));
    tbl.push_back(V(0,1,0,0,1,0,0,       1,32'h4, 1,32'h0,32'h4,D(0)));
    tbl.push_back(V(0,1,0,0,1,1,D(4),    0,32'h4, 0,32'h0,32'h4,B));
    tbl.push_back(V(0,1,0,0,1,0,0,       1,32'h8, 1,32'h4,32'h8,D(4)));
    tbl.push_back(V(0,1,0,0,1,1,D(8),    0,32'h8, 0,32'h4,32'h8,B));
    tbl.push_back(V(0,0,0,0,1,0,0,       1,32'hC, 1,32'h8,32'hC,D(8)));
    tbl.push_back(V(0,0,0,0,0,1,D(12),   0,32'hC, 1,32'h8,32'hC,D(8)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0,0,0,0,0,0,0,     0,32'hC, 1,32'h8,32'hC,D(8)));
    tbl.push_back(V(0,1,0,0,0,0,0,       0,32'hC, 1,32'h8,32'hC,D(8)));
    tbl.push_back(V(0,1,0,0,1,0,0,       1,32'h10,1,32'hC,32'h10,D(12)));
    tbl.push_back(V(0,1,0,0,1,1,D(16),   0,32'h10,0,32'hC,32'h10,B));
    tbl.push_back(V(0,1,0,0,0,0,0,       1,32'h14,1,32'h10,32'h14,D(16)));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("t1[%0d]", i));

    // Redirect while waiting; the stale word arrives two cycles later.
    do_reset();
    run_vec(V(0,1,0,0,0,0,0,            0,32'h0,  0,0,0,B), "t3a");
    run_vec(V(0,1,0,0,1,0,0,            1,32'h0,  0,0,0,B), "t3b");
    run_vec(V(0,1,1,32'h103,0,0,0,      0,32'h0,  0,0,0,B), "t3c");
    run_vec(V(0,1,0,0,0,0,0,            0,32'h100,0,0,0,B), "t3d");
    run_vec(V(0,1,0,0,0,1,D(0),         0,32'h100,0,0,0,B), "t3e");
    run_vec(V(0,1,0,0,1,0,0,            1,32'h100,0,0,0,B), "t3f");
    run_vec(V(0,1,0,0,0,1,D(32'h100),   0,32'h100,0,0,0,B), "t3g");
    run_vec(V(0,1,0,0,0,0,0,            1,32'h104,1,32'h100,32'h104,D(32'h100)), "t3h");

    // Redirect coinciding with rvalid: no DROP, next rvalid is loaded.
    do_reset();
    run_vec(V(0,1,0,0,0,0,0,            0,32'h0,  0,0,0,B), "t4a");
    run_vec(V(0,1,0,0,1,0,0,            1,32'h0,  0,0,0,B), "t4b");
    run_vec(V(0,1,1,32'h200,0,1,D(0),   0,32'h0,  0,0,0,B), "t4c");
    run_vec(V(0,1,0,0,1,0,0,            1,32'h200,0,0,0,B), "t4d");
    run_vec(V(0,1,0,0,0,1,D(32'h200),   0,32'h200,0,0,0,B), "t4e");
    run_vec(V(0,1,0,0,0,0,0,            1,32'h204,1,32'h200,32'h204,D(32'h200)), "t4f");

    // Address wrap at the top of memory, then reset while waiting.
    do_reset();
    run_vec(V(0,1,0,0,0,0,0,                 0,32'h0,        0,0,0,B), "t5a");
    run_vec(V(0,1,1,32'hFFFF_FFFF,0,0,0,     1,32'h0,        0,0,0,B), "t5b");
    run_vec(V(0,1,0,0,1,0,0,                 1,32'hFFFF_FFFC,0,0,0,B), "t5c");
    run_vec(V(0,1,0,0,0,1,D(32'hFFFF_FFFC),  0,32'hFFFF_FFFC,0,0,0,B), "t5d");
    run_vec(V(0,0,0,0,1,0,0,                 1,32'h0,1,32'hFFFF_FFFC,32'h0,D(32'hFFFF_FFFC)), "t5e");
    run_vec(V(1,0,0,0,0,0,0,                 0,32'h0,1,32'hFFFF_FFFC,32'h0,D(32'hFFFF_FFFC)), "t5f");
    run_vec(V(0,1,0,0,0,0,0,                 0,32'h0,        0,0,0,B), "t5g");
    run_vec(V(0,1,0,0,0,0,0,                 1,32'h0,        0,0,0,B), "t5h");

    // Randomized traffic: presented instructions must follow program order.
    do_reset();
    mem_out = 0; mem_cnt = 0; mem_addr = '0; idle = 0; consumed = 0;
    exp_pc = 32'h0; prev_stall = 1'b0; prev_pc = '0; prev_inst = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!inst_valid_o) chk("rnd.bubble", inst_o, B);
      if (imem_addr[1:0] != 2'b00) chk("rnd.align", imem_addr, imem_addr & ~32'h3);
      if (prev_stall) begin
        chk("rnd.frz_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("rnd.frz_pc", pc_o, prev_pc);
        chk("rnd.frz_inst", inst_o, prev_inst);
      end
      if (inst_valid_o) idle = 0;
      else idle++;
      if (idle > 100) begin
        chk("rnd.timeout", idle, 0);
        idle = 0;
      end

      rst         = ($urandom_range(0, 299) == 0);
      haz         = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      imem_gnt    = ($urandom_range(0, 2) != 0);
      if (mem_out != 0 && mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = D(mem_addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end

      if (rst) begin
        mem_out = 0; exp_pc = 32'h0; prev_stall = 1'b0;
      end else begin
        if (inst_valid_o && haz && !redirect) begin
          chk("rnd.pc", pc_o, exp_pc);
          chk("rnd.inst", inst_o, D(exp_pc));
          chk("rnd.ppf", pcPlusFour_o, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (redirect) exp_pc = redirect_pc & ~32'h3;
        prev_stall = inst_valid_o && !haz && !redirect;
        prev_pc    = pc_o;
        prev_inst  = inst_o;
        if (imem_rvalid) mem_out = 0;
        else if (mem_out != 0) mem_cnt--;
        if (imem_req && imem_gnt) begin
          chk("rnd.one_outstanding", mem_out, 0);
          mem_out  = 1;
          mem_addr = imem_addr;
          mem_cnt  = $urandom_range(0, 2);
        end
      end
      @(posedge clk); @(negedge clk);
    end
    chk("rnd.progress", {31'd0, consumed > 300}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
